// File: rtl/pulse_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_counter_bank_pkg
// Description : Shared mode encoding and default parameters for the pulse
//               counter bank and its per-channel counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_counter_bank_pkg;

    // Behaviour when a counted event arrives with count at (or above) limit
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Default bank geometry
    localparam int PCB_DW          = 8;
    localparam int PCB_NCH         = 4;
    localparam int PCB_SELW        = 2;
    localparam int PCB_CLR_ON_SNAP = 0;

endpackage : pulse_counter_bank_pkg
`default_nettype wire

// File: rtl/dffr.sv
`default_nettype none
// ============================================================================
// Module      : dffr
// Description : W-bit register, asynchronous active-low reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Capture next state; reset clears immediately without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_q <= '0;
        else        o_q <= i_d;
    end

endmodule : dffr
`default_nettype wire

// File: rtl/pulse_counter_ch.sv
`default_nettype none
// ============================================================================
// Module      : pulse_counter_ch
// Description : One counter channel: rising-edge detect, limited count with
//               wrap/saturate behaviour, sticky overflow and clear inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_counter_ch
    import pulse_counter_bank_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_mode_sat,
    input  logic [DW-1:0] i_limit,
    input  logic          i_evt,
    input  logic          i_clr,
    input  logic          i_snap_clr,
    output logic [DW-1:0] o_count,
    output logic          o_ovf
);

    localparam logic [DW-1:0] c_one = {{(DW-1){1'b0}}, 1'b1};

    logic          r_evt_q;
    logic [DW-1:0] r_count;
    logic          r_ovf;
    logic          w_hit;
    logic [DW-1:0] w_count_nxt;
    logic          w_ovf_nxt;

    // Next state: clear beats snapshot-clear beats counting. A count above a
    // lowered limit is handled like count == limit.
    always_comb begin
        w_hit       = i_evt & ~r_evt_q & i_en;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        if (i_clr) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (i_snap_clr) begin
            w_count_nxt = w_hit ? c_one : '0;
        end else if (w_hit) begin
            if (r_count < i_limit) begin
                w_count_nxt = r_count + c_one;
            end else begin
                w_count_nxt = (i_mode_sat == MODE_SAT) ? r_count : '0;
                w_ovf_nxt   = 1'b1;
            end
        end
    end

    // Event history tracks the input regardless of enable
    dffr #(.W(1)) u_evt_q (.clk(clk), .rst_n(rst_n), .i_d(i_evt), .o_q(r_evt_q));
    dffr #(.W(DW)) u_count (.clk(clk), .rst_n(rst_n), .i_d(w_count_nxt), .o_q(r_count));
    dffr #(.W(1)) u_ovf (.clk(clk), .rst_n(rst_n), .i_d(w_ovf_nxt), .o_q(r_ovf));

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule : pulse_counter_ch
`default_nettype wire

// File: rtl/pulse_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : pulse_counter_bank
// Description : NCH independent edge counters with shared limit/mode, sticky
//               overflow, per-channel clear and a snapshot read port.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_counter_bank
    import pulse_counter_bank_pkg::*;
#(
    parameter int DW          = PCB_DW,
    parameter int NCH         = PCB_NCH,
    parameter int SELW        = PCB_SELW,
    parameter int CLR_ON_SNAP = PCB_CLR_ON_SNAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode_sat,
    input  logic [DW-1:0]     limit,
    input  logic [NCH-1:0]    evt,
    input  logic [NCH-1:0]    clr,
    input  logic              snap_req,
    input  logic [SELW-1:0]   snap_sel,
    output logic              snap_vld,
    output logic [DW-1:0]     snap_data,
    output logic [NCH*DW-1:0] cnt,
    output logic [NCH-1:0]    tc,
    output logic [NCH-1:0]    ovf
);

    logic [NCH-1:0] w_snap_hit;
    logic [DW-1:0]  w_sel_cnt;
    logic [DW-1:0]  w_snap_data_nxt;
    logic [DW-1:0]  r_snap_data;
    logic           r_snap_vld;

    // One counter per channel; snapshot selection decoded per channel so an
    // out-of-range index simply matches nothing
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign w_snap_hit[gi] = snap_req & (snap_sel == SELW'(gi));

        pulse_counter_ch #(.DW(DW)) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_en       (en),
            .i_mode_sat (mode_sat),
            .i_limit    (limit),
            .i_evt      (evt[gi]),
            .i_clr      (clr[gi]),
            .i_snap_clr ((CLR_ON_SNAP != 0) & w_snap_hit[gi]),
            .o_count    (cnt[gi*DW +: DW]),
            .o_ovf      (ovf[gi])
        );

        assign tc[gi] = (cnt[gi*DW +: DW] == limit);
    end

    // Snapshot mux: OR of one-hot selected counts, zero when nothing selected
    always_comb begin
        w_sel_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_snap_hit[i]) w_sel_cnt = w_sel_cnt | cnt[i*DW +: DW];
        end
        w_snap_data_nxt = snap_req ? w_sel_cnt : r_snap_data;
    end

    dffr #(.W(DW)) u_snap_data (.clk(clk), .rst_n(rst_n), .i_d(w_snap_data_nxt), .o_q(r_snap_data));
    dffr #(.W(1))  u_snap_vld  (.clk(clk), .rst_n(rst_n), .i_d(snap_req), .o_q(r_snap_vld));

    assign snap_data = r_snap_data;
    assign snap_vld  = r_snap_vld;

endmodule : pulse_counter_bank
`default_nettype wire

// File: tb/tb_pulse_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_counter_bank
// Description : Self-checking bench for pulse_counter_bank with a behavioural
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_counter_bank;

    localparam int DW          = 8;
    localparam int NCH         = 4;
    localparam int SELW        = 3;
    localparam int CLR_ON_SNAP = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              mode_sat = 1'b0;
    logic [DW-1:0]     limit = '0;
    logic [NCH-1:0]    evt = '0;
    logic [NCH-1:0]    clr = '0;
    logic              snap_req = 1'b0;
    logic [SELW-1:0]   snap_sel = '0;
    logic              snap_vld;
    logic [DW-1:0]     snap_data;
    logic [NCH*DW-1:0] cnt;
    logic [NCH-1:0]    tc;
    logic [NCH-1:0]    ovf;

    pulse_counter_bank #(
        .DW(DW), .NCH(NCH), .SELW(SELW), .CLR_ON_SNAP(CLR_ON_SNAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_sat(mode_sat), .limit(limit),
        .evt(evt), .clr(clr), .snap_req(snap_req), .snap_sel(snap_sel),
        .snap_vld(snap_vld), .snap_data(snap_data), .cnt(cnt), .tc(tc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // Reference state
    int m_cnt  [NCH];
    bit m_ovf  [NCH];
    bit m_evtq [NCH];
    int m_sd;
    bit m_sv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_evtq[i] = 0;
        end
        m_sd = 0; m_sv = 0;
    endtask

    // Apply the counting rules for one rising edge using the stable inputs
    task automatic model_edge();
        int  lim;
        bit  ev;
        lim = int'(limit);
        if (snap_req) m_sd = (int'(snap_sel) < NCH) ? m_cnt[int'(snap_sel)] : 0;
        m_sv = snap_req;
        for (int i = 0; i < NCH; i++) begin
            ev = evt[i] && !m_evtq[i] && en;
            if (clr[i]) begin
                m_cnt[i] = 0;
                m_ovf[i] = 0;
            end else if (CLR_ON_SNAP != 0 && snap_req && int'(snap_sel) == i) begin
                m_cnt[i] = ev ? 1 : 0;
            end else if (ev) begin
                if (m_cnt[i] < lim) begin
                    m_cnt[i] = m_cnt[i] + 1;
                end else begin
                    if (!mode_sat) m_cnt[i] = 0;
                    m_ovf[i] = 1;
                end
            end
            m_evtq[i] = evt[i];
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("cnt%0d", i), cnt[i*DW +: DW], m_cnt[i]);
            chk($sformatf("ovf%0d", i), ovf[i], m_ovf[i]);
            chk($sformatf("tc%0d", i), tc[i], m_cnt[i] == int'(limit));
        end
        chk("snap_vld", snap_vld, m_sv);
        chk("snap_data", snap_data, m_sd);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pulse(input logic [NCH-1:0] m);
        evt = m; tick();
        evt = '0; tick();
    endtask

    int wrap_exp [5] = '{1, 2, 3, 0, 1};

    initial begin
        model_reset();
        #12;
        rst_n = 1'b1;
        chk("reset_cnt", cnt, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_vld", snap_vld, 0);

        // 1. Reset mid-count
        en = 1'b1; limit = 8'd255; mode_sat = 1'b0;
        for (int k = 0; k < 5; k++) pulse(4'b0001);
        chk("pre_rst_cnt0", cnt[0 +: DW], 5);
        snap_req = 1'b1; snap_sel = 3'd0; tick();
        snap_req = 1'b0;
        chk("pre_rst_vld", snap_vld, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_ovf", ovf, 0);
        chk("async_rst_vld", snap_vld, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 2. Wrap on channel 1
        limit = 8'd3; mode_sat = 1'b0;
        for (int k = 0; k < 5; k++) begin
            evt = 4'b0010; tick();
            chk("wrap_cnt1", cnt[DW +: DW], wrap_exp[k]);
            chk("wrap_ovf1", ovf[1], k >= 3);
            chk("wrap_tc1", tc[1], wrap_exp[k] == 3);
            evt = '0; tick();
        end

        // 3. Saturate then clear with coincident event
        mode_sat = 1'b1;
        for (int k = 0; k < 6; k++) pulse(4'b0100);
        chk("sat_cnt2", cnt[2*DW +: DW], 3);
        chk("sat_ovf2", ovf[2], 1);
        clr = 4'b0100; evt = 4'b0100; tick();
        chk("clr_cnt2", cnt[2*DW +: DW], 0);
        chk("clr_ovf2", ovf[2], 0);
        clr = '0; evt = '0; tick();

        // 4. Level held high counts once; disabled pulses ignored
        limit = 8'd255; mode_sat = 1'b0;
        clr = 4'b0001; tick(); clr = '0;
        evt = 4'b0001;
        for (int k = 0; k < 10; k++) tick();
        chk("level_cnt0", cnt[0 +: DW], 1);
        evt = '0; tick();
        en = 1'b0;
        for (int k = 0; k < 3; k++) pulse(4'b0001);
        chk("dis_cnt0", cnt[0 +: DW], 1);
        evt = 4'b0001; tick();
        en = 1'b1; tick();
        chk("reen_held_cnt0", cnt[0 +: DW], 1);
        evt = '0; tick();
        pulse(4'b0001);
        chk("reen_cnt0", cnt[0 +: DW], 2);

        // 5. Snapshot with clear-on-snap and coincident event
        clr = 4'b1000; tick(); clr = '0;
        for (int k = 0; k < 7; k++) pulse(4'b1000);
        chk("pre_snap_cnt3", cnt[3*DW +: DW], 7);
        snap_req = 1'b1; snap_sel = 3'd3; evt = 4'b1000; tick();
        chk("snap_vld", snap_vld, 1);
        chk("snap_data7", snap_data, 7);
        chk("snap_cnt3", cnt[3*DW +: DW], 1);
        evt = '0; snap_sel = 3'(NCH); tick();
        chk("snap_oor_data", snap_data, 0);
        chk("snap_oor_cnt3", cnt[3*DW +: DW], 1);
        snap_req = 1'b0; tick();
        chk("snap_vld_drop", snap_vld, 0);

        // 6. All channels with limit 0
        clr = '1; tick(); clr = '0;
        limit = 8'd0;
        evt = '1; tick();
        chk("lim0_cnt", cnt, 0);
        chk("lim0_ovf", ovf, 4'hF);
        evt = '0; tick();

        // Random traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            en       = ($urandom_range(0, 9) != 0);
            mode_sat = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       limit = 8'($urandom_range(0, 7));
                1:       limit = 8'd255;
                default: if ($urandom_range(0, 7) == 0) limit = 8'($urandom);
            endcase
            evt = NCH'($urandom);
            for (int i = 0; i < NCH; i++) clr[i] = ($urandom_range(0, 15) == 0);
            snap_req = ($urandom_range(0, 3) == 0);
            snap_sel = SELW'($urandom_range(0, 7));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule : tb_pulse_counter_bank
`default_nettype wire
